// File: rtl/loop_ctrl_pkg.sv
// Shared types and helpers for the loop gain scheduler: FSM state encoding
// and the gear-to-gain shift with a floor of one.
package loop_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    // A gain never collapses to zero, however far the base is shifted down.
    function automatic int unsigned gain_for_shift(input int unsigned base,
                                                   input int unsigned shift);
        int unsigned g;
        g = (shift >= 32) ? 0 : (base >> shift);
        return (g == 0) ? 1 : g;
    endfunction

endpackage

// File: rtl/quiet_counter.sv
// Saturating |error|, quiet/unlock threshold compares and the consecutive
// quiet-sample counter used by the gain scheduler FSM.
module quiet_counter #(
    parameter int unsigned ERROR_WIDTH   = 8,
    parameter int unsigned QUIET_THRESH  = 4,
    parameter int unsigned QUIET_CYCLES  = 16,
    parameter int unsigned UNLOCK_THRESH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic signed [ERROR_WIDTH-1:0] error_i,
    input  logic                          clear_i,
    output logic                          hit_o,
    output logic                          unlock_o
);

    localparam int unsigned CNT_WIDTH = $clog2(QUIET_CYCLES + 1);
    localparam logic [ERROR_WIDTH-1:0] MOST_NEG = {1'b1, {(ERROR_WIDTH-1){1'b0}}};
    localparam logic [ERROR_WIDTH-1:0] MAX_POS  = {1'b0, {(ERROR_WIDTH-1){1'b1}}};

    logic [ERROR_WIDTH-1:0] mag;
    logic                   quiet;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    // The most-negative code has no positive twin; clamp it instead of wrapping.
    always_comb begin
        mag = error_i;
        if (error_i[ERROR_WIDTH-1]) begin
            mag = (error_i == MOST_NEG) ? MAX_POS : (~error_i + 1'b1);
        end
    end

    assign quiet    = (32'(mag) <= QUIET_THRESH);
    assign unlock_o = (32'(mag) > UNLOCK_THRESH);
    assign hit_o    = quiet && (cnt_q >= CNT_WIDTH'(QUIET_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !quiet) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_WIDTH'(QUIET_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/loop_gain_scheduler.sv
// PLL loop gain scheduler: steps down kp/ki through gears as the phase error
// stays quiet, declares lock, and falls back to acquisition on large errors.
module loop_gain_scheduler
    import loop_ctrl_pkg::*;
#(
    parameter int unsigned ERROR_WIDTH   = 8,
    parameter int unsigned KP_WIDTH      = 5,
    parameter int unsigned KI_WIDTH      = 11,
    parameter int unsigned KP_BASE       = 16,
    parameter int unsigned KI_BASE       = 512,
    parameter int unsigned NUM_GEARS     = 4,
    parameter int unsigned QUIET_THRESH  = 4,
    parameter int unsigned QUIET_CYCLES  = 16,
    parameter int unsigned UNLOCK_THRESH = 32
) (
    input  logic                          gen_clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic signed [ERROR_WIDTH-1:0] error_i,
    output logic [KP_WIDTH-1:0]           kp_o,
    output logic [KI_WIDTH-1:0]           ki_o,
    output logic [$clog2(NUM_GEARS)-1:0]  gear_o,
    output logic                          locked_o,
    output logic [1:0]                    state_o
);

    localparam int unsigned GEAR_WIDTH = $clog2(NUM_GEARS);
    localparam logic [GEAR_WIDTH-1:0] TOP_GEAR = GEAR_WIDTH'(NUM_GEARS - 1);

    state_e                state_q, state_d;
    logic [GEAR_WIDTH-1:0] gear_q, gear_d;
    logic [KP_WIDTH-1:0]   kp_q, kp_d;
    logic [KI_WIDTH-1:0]   ki_q, ki_d;
    logic                  locked_q, locked_d;
    logic                  hit, unlock, clear;

    quiet_counter #(
        .ERROR_WIDTH  (ERROR_WIDTH),
        .QUIET_THRESH (QUIET_THRESH),
        .QUIET_CYCLES (QUIET_CYCLES),
        .UNLOCK_THRESH(UNLOCK_THRESH)
    ) u_quiet (
        .clk_i   (gen_clk_i),
        .rst_i   (reset_i),
        .error_i (error_i),
        .clear_i (clear),
        .hit_o   (hit),
        .unlock_o(unlock)
    );

    always_comb begin
        state_d = state_q;
        gear_d  = gear_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
            gear_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    gear_d  = '0;
                end
                ST_ACQUIRE: begin
                    if (unlock && (gear_q != '0)) begin
                        gear_d = '0;
                    end else if (hit) begin
                        gear_d = gear_q + 1'b1;
                        if (gear_d == TOP_GEAR) state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (unlock) begin
                        state_d = ST_ACQUIRE;
                        gear_d  = '0;
                    end else if (hit) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (unlock) begin
                        state_d = ST_ACQUIRE;
                        gear_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gear_d  = '0;
                end
            endcase
        end
    end

    // Gains and lock flag follow the next-state values so they move on the same edge as gear_o.
    always_comb begin
        clear    = (state_d != state_q) || (gear_d != gear_q) || (state_q == ST_IDLE);
        kp_d     = KP_WIDTH'(gain_for_shift(KP_BASE, 32'(gear_d)));
        ki_d     = KI_WIDTH'(gain_for_shift(KI_BASE, 32'({gear_d, 1'b0})));
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            gear_q   <= '0;
            kp_q     <= KP_WIDTH'(KP_BASE);
            ki_q     <= KI_WIDTH'(KI_BASE);
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gear_q   <= gear_d;
            kp_q     <= kp_d;
            ki_q     <= ki_d;
            locked_q <= locked_d;
        end
    end

    assign kp_o     = kp_q;
    assign ki_o     = ki_q;
    assign gear_o   = gear_q;
    assign locked_o = locked_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_loop_gain_scheduler.sv
// Self-checking bench for loop_gain_scheduler: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_loop_gain_scheduler;

    logic              clk;
    logic              reset;
    logic              enable;
    logic signed [7:0] error;

    logic [4:0]  kp,  kp2;
    logic [10:0] ki,  ki2;
    logic [1:0]  gear, gear2;
    logic        locked, locked2;
    logic [1:0]  state, state2;

    int checks;
    int failures;

    // Behavioural model: state, gear and length of the current quiet run.
    int m_state;
    int m_gear;
    int m_run;

    loop_gain_scheduler dut (
        .gen_clk_i(clk),
        .reset_i  (reset),
        .enable_i (enable),
        .error_i  (error),
        .kp_o     (kp),
        .ki_o     (ki),
        .gear_o   (gear),
        .locked_o (locked),
        .state_o  (state)
    );

    loop_gain_scheduler #(.KP_BASE(2)) dut2 (
        .gen_clk_i(clk),
        .reset_i  (reset),
        .enable_i (enable),
        .error_i  (error),
        .kp_o     (kp2),
        .ki_o     (ki2),
        .gear_o   (gear2),
        .locked_o (locked2),
        .state_o  (state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0;
        m_gear  = 0;
        m_run   = 0;
    endtask

    task automatic model_step(input bit en, input int err);
        int a, ns, ng;
        bit quiet, unl;
        a = (err < 0) ? -err : err;
        if (a > 127) a = 127;
        quiet = (a <= 4);
        unl   = (a > 32);
        ns = m_state;
        ng = m_gear;
        if (!en) begin
            ns = 0; ng = 0;
        end else begin
            case (m_state)
                0: begin ns = 1; ng = 0; end
                1: begin
                    if (unl && m_gear > 0) ng = 0;
                    else if (quiet && m_run + 1 >= 16) begin
                        ng = m_gear + 1;
                        if (ng == 3) ns = 2;
                    end
                end
                2: begin
                    if (unl) begin ns = 1; ng = 0; end
                    else if (quiet && m_run + 1 >= 16) ns = 3;
                end
                default: begin
                    if (unl) begin ns = 1; ng = 0; end
                end
            endcase
        end
        if (ns != m_state || ng != m_gear || m_state == 0) m_run = 0;
        else if (quiet) m_run = (m_run + 1 > 16) ? 16 : m_run + 1;
        else m_run = 0;
        m_state = ns;
        m_gear  = ng;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(enable, int'(error));
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        error  = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; error = '0;
        #3;
        checks++;
        if ({state, gear, kp, ki, locked} !== {2'd0, 2'd0, 5'd16, 11'd512, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: got st=%0d g=%0d kp=%0d ki=%0d lk=%0d required 0 0 16 512 0",
                     state, gear, kp, ki, locked);
        end
        @(posedge clk); #1;
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL reset_held: state=%0d required 0", state);
        end
        do_reset();
    endtask

    task automatic test_acquire_sequence();
        do_reset();
        enable = 1'b1; error = '0;
        cycle();
        checks++;
        if (state !== 2'd1 || gear !== 2'd0) begin
            failures++;
            $display("FAIL enter_acquire: st=%0d g=%0d required 1 0", state, gear);
        end
        for (int k = 1; k <= 64; k++) begin
            cycle();
            if (k == 15) begin
                checks++;
                if (gear !== 2'd0) begin
                    failures++;
                    $display("FAIL gear_early: gear=%0d required 0", gear);
                end
            end
            if (k == 16) begin
                checks++;
                if ({state, gear, kp, ki} !== {2'd1, 2'd1, 5'd8, 11'd128}) begin
                    failures++;
                    $display("FAIL gear1: st=%0d g=%0d kp=%0d ki=%0d required 1 1 8 128", state, gear, kp, ki);
                end
            end
            if (k == 32) begin
                checks++;
                if ({state, gear, kp, ki} !== {2'd1, 2'd2, 5'd4, 11'd32}) begin
                    failures++;
                    $display("FAIL gear2: st=%0d g=%0d kp=%0d ki=%0d required 1 2 4 32", state, gear, kp, ki);
                end
            end
            if (k == 48) begin
                checks++;
                if ({state, gear, kp, ki} !== {2'd2, 2'd3, 5'd2, 11'd8}) begin
                    failures++;
                    $display("FAIL track: st=%0d g=%0d kp=%0d ki=%0d required 2 3 2 8", state, gear, kp, ki);
                end
            end
            if (k == 63) begin
                checks++;
                if (locked !== 1'b0) begin
                    failures++;
                    $display("FAIL lock_early: locked=%0d required 0", locked);
                end
            end
            if (k == 64) begin
                checks++;
                if (locked !== 1'b1 || state !== 2'd3) begin
                    failures++;
                    $display("FAIL lock: locked=%0d st=%0d required 1 3", locked, state);
                end
            end
        end
    endtask

    task automatic test_locked_tolerance();
        int bad;
        do_reset();
        enable = 1'b1; error = '0;
        repeat (65) cycle();
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            case (k % 4)
                0: error = 8'sd20;
                1: error = -8'sd32;
                2: error = 8'sd32;
                default: error = 8'sd5;
            endcase
            cycle();
            if (state !== 2'd3 || locked !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_lock: %0d cycles out of lock, required 0", bad);
        end
        error = 8'sd33;
        cycle();
        checks++;
        if ({state, gear, kp, ki, locked} !== {2'd1, 2'd0, 5'd16, 11'd512, 1'b0}) begin
            failures++;
            $display("FAIL drop_lock: st=%0d g=%0d kp=%0d ki=%0d lk=%0d required 1 0 16 512 0",
                     state, gear, kp, ki, locked);
        end
    endtask

    task automatic test_neg_saturation();
        do_reset();
        enable = 1'b1; error = '0;
        repeat (33) cycle();
        checks++;
        if (gear !== 2'd2) begin
            failures++;
            $display("FAIL reach_gear2: gear=%0d required 2", gear);
        end
        error = -8'sd128;
        cycle();
        checks++;
        if ({state, gear, kp} !== {2'd1, 2'd0, 5'd16}) begin
            failures++;
            $display("FAIL neg_unlock: st=%0d g=%0d kp=%0d required 1 0 16", state, gear, kp);
        end
        repeat (20) cycle();
        checks++;
        if (gear !== 2'd0 || state !== 2'd1) begin
            failures++;
            $display("FAIL neg_not_quiet: st=%0d g=%0d required 1 0", state, gear);
        end
    endtask

    task automatic test_quiet_break();
        do_reset();
        enable = 1'b1; error = '0;
        cycle();
        for (int k = 0; k < 15; k++) begin
            error = (k % 2 == 0) ? 8'sd4 : -8'sd4;
            cycle();
        end
        error = 8'sd5;
        cycle();
        for (int k = 0; k < 15; k++) begin
            error = (k % 2 == 0) ? -8'sd4 : 8'sd0;
            cycle();
        end
        checks++;
        if (gear !== 2'd0) begin
            failures++;
            $display("FAIL quiet_break: gear=%0d required 0", gear);
        end
        error = 8'sd4;
        cycle();
        checks++;
        if (gear !== 2'd1) begin
            failures++;
            $display("FAIL quiet_16th: gear=%0d required 1", gear);
        end
    endtask

    task automatic test_disable_and_reset();
        do_reset();
        enable = 1'b1; error = '0;
        repeat (65) cycle();
        enable = 1'b0;
        cycle();
        checks++;
        if ({state, gear, kp, ki, locked} !== {2'd0, 2'd0, 5'd16, 11'd512, 1'b0}) begin
            failures++;
            $display("FAIL disable: st=%0d g=%0d kp=%0d ki=%0d lk=%0d required 0 0 16 512 0",
                     state, gear, kp, ki, locked);
        end
        enable = 1'b1;
        repeat (49) cycle();
        checks++;
        if (state !== 2'd2) begin
            failures++;
            $display("FAIL pre_reset_track: st=%0d required 2", state);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({state, gear, kp, ki, locked} !== {2'd0, 2'd0, 5'd16, 11'd512, 1'b0}) begin
            failures++;
            $display("FAIL async_reset: st=%0d g=%0d kp=%0d ki=%0d lk=%0d required 0 0 16 512 0",
                     state, gear, kp, ki, locked);
        end
        #1 reset = 1'b0;
        model_reset();
        cycle();
        checks++;
        if (state !== 2'd1 || gear !== 2'd0) begin
            failures++;
            $display("FAIL restart: st=%0d g=%0d required 1 0", state, gear);
        end
        repeat (15) cycle();
        checks++;
        if (gear !== 2'd0) begin
            failures++;
            $display("FAIL progress_discarded: gear=%0d required 0", gear);
        end
    endtask

    task automatic test_kp_clamp();
        int zeros;
        do_reset();
        enable = 1'b1; error = '0;
        cycle();
        checks++;
        if (kp2 !== 5'd2) begin
            failures++;
            $display("FAIL clamp_gear0: kp=%0d required 2", kp2);
        end
        zeros = 0;
        for (int k = 1; k <= 64; k++) begin
            cycle();
            if (kp2 == 5'd0) zeros++;
            if (k == 16 || k == 32 || k == 48) begin
                checks++;
                if (kp2 !== 5'd1) begin
                    failures++;
                    $display("FAIL clamp_kp step %0d: kp=%0d gear=%0d required 1", k, kp2, gear2);
                end
            end
        end
        checks++;
        if (zeros != 0 || gear2 !== 2'd3) begin
            failures++;
            $display("FAIL clamp_nonzero: zero cycles=%0d gear=%0d required 0 3", zeros, gear2);
        end
    endtask

    task automatic test_random();
        int mode, len, ekp, eki;
        logic [20:0] exp_v, got_v;
        do_reset();
        enable = 1'b1; error = '0;
        for (int seg = 0; seg < 90; seg++) begin
            mode = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 40));
            if (mode == 9) len = int'($urandom_range(1, 3));
            for (int c = 0; c < len; c++) begin
                enable = (mode != 9);
                if (mode <= 6)      error = 8'(int'($urandom_range(0, 8)) - 4);
                else if (mode == 7) error = 8'(int'($urandom_range(0, 64)) - 32);
                else                error = 8'($urandom);
                cycle();
                ekp = 16 >> m_gear; if (ekp == 0) ekp = 1;
                eki = 512 >> (2 * m_gear); if (eki == 0) eki = 1;
                exp_v = {2'(m_state), 2'(m_gear), 5'(ekp), 11'(eki), (m_state == 3)};
                got_v = {state, gear, kp, ki, locked};
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL random seg %0d: got st=%0d g=%0d kp=%0d ki=%0d lk=%0d required st=%0d g=%0d kp=%0d ki=%0d lk=%0d",
                             seg, state, gear, kp, ki, locked, m_state, m_gear, ekp, eki, (m_state == 3));
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        error    = '0;
        model_reset();
        test_reset();
        test_acquire_sequence();
        test_locked_tolerance();
        test_neg_saturation();
        test_quiet_break();
        test_disable_and_reset();
        test_kp_clamp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/loop_gain_scheduler.md
LOOP_GAIN_SCHEDULER -- requirements
Module: loop_gain_scheduler

Interface
REQ-001 ERROR_WIDTH, 8, width of signed phase error.
REQ-002 KP_WIDTH, 5, proportional gain width.
REQ-003 KI_WIDTH, 11, integral gain width.
REQ-004 KP_BASE, 16, gear-0 proportional gain.
REQ-005 KI_BASE, 512, gear-0 integral gain.
REQ-006 NUM_GEARS, 4, gear count; gear NUM_GEARS-1 is the tracking gear.
REQ-007 QUIET_THRESH, 4, |error| at or below this makes a sample quiet.
REQ-008 QUIET_CYCLES, 16, consecutive quiet samples needed to shift gear or declare lock.
REQ-009 UNLOCK_THRESH, 32, |error| above this is a loss-of-lock sample.
REQ-010 gen_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-011 reset_i  in  1  asynchronous, active-high reset.
REQ-012 enable_i  in  1  run request; low forces IDLE.
REQ-013 error_i  in  ERROR_WIDTH signed  phase error, sampled every edge.
REQ-014 kp_o  out  KP_WIDTH  proportional gain to loop filter kp_i.
REQ-015 ki_o  out  KI_WIDTH  integral gain to loop filter ki_i.
REQ-016 gear_o  out  $clog2(NUM_GEARS)  current gear index.
REQ-017 locked_o  out  1  lock indicator.
REQ-018 state_o  out  2  FSM state: IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3.

Function
REQ-019 |error| SHALL be computed with the most-negative value saturated to 2^(ERROR_WIDTH-1)-1.
REQ-020 quiet_cnt SHALL increment on each quiet sample, saturate at QUIET_CYCLES, and clear on any non-quiet sample, any gear change and any state change.
REQ-021 IDLE: gear 0, locked_o 0, quiet_cnt held 0; enable_i high -> ACQUIRE on next edge.
REQ-022 ACQUIRE: the edge sampling the QUIET_CYCLES-th consecutive quiet sample SHALL increment gear; if the new gear equals NUM_GEARS-1, state -> TRACK on the same edge.
REQ-023 ACQUIRE with gear > 0: |error| > UNLOCK_THRESH SHALL reset gear to 0, state unchanged.
REQ-024 TRACK: QUIET_CYCLES consecutive quiet samples -> LOCKED, locked_o high on that edge; |error| > UNLOCK_THRESH -> ACQUIRE, gear 0.
REQ-025 LOCKED: |error| > UNLOCK_THRESH -> ACQUIRE, gear 0, locked_o low on that edge; samples between QUIET_THRESH and UNLOCK_THRESH SHALL NOT drop lock.
REQ-026 enable_i low SHALL force IDLE on the next edge from any state, overriding all other transitions.
REQ-027 kp_o = max(KP_BASE >> gear, 1) and ki_o = max(KI_BASE >> (2*gear), 1), registered so they change on the same edge as gear_o.
REQ-028 All outputs SHALL be registered; decisions use error_i as sampled on the edge, giving one-cycle latency from error_i to outputs.

Reset
REQ-029 reset_i high SHALL immediately force state IDLE, gear 0, kp_o=KP_BASE, ki_o=KI_BASE, locked_o 0, quiet_cnt 0, independent of gen_clk_i.
REQ-030 Reset asserted mid-acquisition or while locked SHALL discard all progress; after release, operation restarts from IDLE.

Structure
REQ-031 Package loop_ctrl_pkg SHALL hold the state enum and the gear-to-gain shift function.
REQ-032 Sub-module quiet_counter SHALL contain the saturating abs, threshold compare and saturating quiet_cnt; the FSM and gain registers stay in the top.

Verification
REQ-033 Defaults, error_i=0, enable_i rises before edge e -> state 1 after e; gear 1 (kp 8, ki 128) after e+16; gear 2 (4, 32) after e+32; TRACK gear 3 (2, 8) after e+48; locked_o high after e+64.
REQ-034 Locked, error_i=20 for 100 cycles -> stays LOCKED; one sample error_i=33 -> ACQUIRE, gear 0, kp 16, ki 512, locked_o 0 on that edge.
REQ-035 ACQUIRE at gear 2, error_i=-128 -> abs saturates to 127; gear resets to 0; no sign-wrap false quiet.
REQ-036 15 quiet samples, one error_i=5, then 15 quiet -> no gear shift; 16th consecutive quiet shifts.
REQ-037 enable_i low while LOCKED -> IDLE next edge, outputs at reset values; reset_i pulsed between clock edges mid-TRACK -> outputs reset before the next edge.
REQ-038 KP_BASE=2, NUM_GEARS=4 -> kp_o clamps to 1 at gears 2 and 3, never 0.
